// File: rtl/scarv_mmio_timer_pkg.sv
// Shared constants and types for the memory-mapped machine timer.
// Holds the word offsets, the CTRL enable bit index and the 64-bit time type.
package scarv_mmio_timer_pkg;

    typedef logic [63:0] mtime_t;

    localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
    localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] OFF_CTRL        = 3'd4;
    localparam logic [2:0] OFF_PRESCALE    = 3'd5;

    localparam int CTRL_EN_BIT = 0;

    // Byte-lane merge of a write into an existing 32-bit word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/scarv_mmio_timer_if.sv
// Data-bus connection between the core and the timer register window.
// Requests are always accepted; read data returns one cycle later.
interface scarv_mmio_timer_if;

    logic        req_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  strb_i;
    logic        we_i;
    logic [31:0] rdata_o;

    modport master (output req_i, addr_i, wdata_i, strb_i, we_i, input rdata_o);
    modport slave  (input req_i, addr_i, wdata_i, strb_i, we_i, output rdata_o);

endinterface

// File: rtl/scarv_timer_prescaler.sv
// Prescaler for the machine timer: counts 0..limit while enabled and
// raises tick for the cycle in which the count sits at limit.
module scarv_timer_prescaler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en,
    input  logic [15:0] limit,
    input  logic        clear,
    output logic        tick
);

    logic [15:0] count;

    assign tick = en && (count == limit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= 16'd0;
        end else if (clear || tick) begin
            count <= 16'd0;
        end else if (en) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/scarv_mmio_timer.sv
// Memory-mapped 64-bit machine timer with compare interrupt and prescaler.
// Bus writes to mtime take priority over, and suppress, a same-cycle tick.
module scarv_mmio_timer
    import scarv_mmio_timer_pkg::*;
#(
    parameter logic [31:0] BaseAddr = 32'h0000_3000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    scarv_mmio_timer_if.slave  bus,
    output logic               int_timer_o
);

    logic        sel;
    logic        wr;
    logic [2:0]  off;
    logic        tick;
    logic        en;
    logic [15:0] prescale;
    logic [15:0] prescale_nxt;
    logic        prescale_wr;
    logic [31:0] rd_val;
    mtime_t      mtime;
    mtime_t      mtime_nxt;
    mtime_t      mtimecmp;
    mtime_t      mtimecmp_nxt;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^bus.addr_i[1:0];

    assign sel         = bus.req_i && (bus.addr_i[31:5] == BaseAddr[31:5]);
    assign wr          = sel && bus.we_i;
    assign off         = bus.addr_i[4:2];
    assign prescale_wr = wr && (off == OFF_PRESCALE);

    assign prescale_nxt[7:0]  = bus.strb_i[0] ? bus.wdata_i[7:0]  : prescale[7:0];
    assign prescale_nxt[15:8] = bus.strb_i[1] ? bus.wdata_i[15:8] : prescale[15:8];

    scarv_timer_prescaler u_prescaler (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (en),
        .limit (prescale),
        .clear (prescale_wr),
        .tick  (tick)
    );

    always_comb begin
        mtime_nxt = mtime;
        if (wr && off == OFF_MTIME_LO) begin
            mtime_nxt[31:0] = merge_bytes(mtime[31:0], bus.wdata_i, bus.strb_i);
        end else if (wr && off == OFF_MTIME_HI) begin
            mtime_nxt[63:32] = merge_bytes(mtime[63:32], bus.wdata_i, bus.strb_i);
        end else if (tick) begin
            mtime_nxt = mtime + 64'd1;
        end
    end

    always_comb begin
        mtimecmp_nxt = mtimecmp;
        if (wr && off == OFF_MTIMECMP_LO) begin
            mtimecmp_nxt[31:0] = merge_bytes(mtimecmp[31:0], bus.wdata_i, bus.strb_i);
        end else if (wr && off == OFF_MTIMECMP_HI) begin
            mtimecmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], bus.wdata_i, bus.strb_i);
        end
    end

    always_comb begin
        rd_val = 32'd0;
        case (off)
            OFF_MTIME_LO:    rd_val = mtime[31:0];
            OFF_MTIME_HI:    rd_val = mtime[63:32];
            OFF_MTIMECMP_LO: rd_val = mtimecmp[31:0];
            OFF_MTIMECMP_HI: rd_val = mtimecmp[63:32];
            OFF_CTRL:        rd_val = {31'd0, en};
            OFF_PRESCALE:    rd_val = {16'd0, prescale};
            default:         rd_val = 32'd0;
        endcase
    end

    // rdata only moves on a request, so it holds across idle cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime       <= 64'd0;
            mtimecmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
            en          <= 1'b0;
            prescale    <= 16'd0;
            bus.rdata_o <= 32'd0;
            int_timer_o <= 1'b0;
        end else begin
            mtime    <= mtime_nxt;
            mtimecmp <= mtimecmp_nxt;
            if (wr && off == OFF_CTRL && bus.strb_i[0]) begin
                en <= bus.wdata_i[CTRL_EN_BIT];
            end
            if (prescale_wr) begin
                prescale <= prescale_nxt;
            end
            if (bus.req_i) begin
                bus.rdata_o <= (sel && !bus.we_i) ? rd_val : 32'd0;
            end
            int_timer_o <= en && (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_scarv_mmio_timer.sv
// Directed self-checking bench for the memory-mapped machine timer.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_scarv_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic clk;
    logic rst;
    logic int_timer;
    int   checks;
    int   failures;

    scarv_mmio_timer_if bus_if ();

    scarv_mmio_timer #(.BaseAddr(BASE)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus_if.slave),
        .int_timer_o (int_timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: drive inputs, wait for the edge, then return the bus to idle.
    task automatic apply_stimulus(input logic req, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] strb,
                                  input logic we);
        bus_if.req_i   = req;
        bus_if.addr_i  = addr;
        bus_if.wdata_i = wdata;
        bus_if.strb_i  = strb;
        bus_if.we_i    = we;
        @(posedge clk);
        #1;
        bus_if.req_i  = 1'b0;
        bus_if.we_i   = 1'b0;
        bus_if.strb_i = 4'h0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    endtask

    task automatic write_reg(input logic [2:0] o, input logic [31:0] data,
                             input logic [3:0] strb);
        apply_stimulus(1'b1, BASE + {27'd0, o, 2'b00}, data, strb, 1'b1);
    endtask

    task automatic check_read(input string tag, input logic [2:0] o,
                              input logic [31:0] exp);
        apply_stimulus(1'b1, BASE + {27'd0, o, 2'b00}, 32'd0, 4'h0, 1'b0);
        check_output(tag, bus_if.rdata_o, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus_if.req_i   = 1'b0;
        bus_if.addr_i  = 32'd0;
        bus_if.wdata_i = 32'd0;
        bus_if.strb_i  = 4'h0;
        bus_if.we_i    = 1'b0;
        idle(2);
        check_output("reset_rdata", bus_if.rdata_o, 32'd0);
        check_output("reset_int", {31'd0, int_timer}, 32'd0);
        rst = 1'b0;

        // Reset values of every offset
        check_read("rst_mtime_lo", 3'd0, 32'h0000_0000);
        check_read("rst_mtime_hi", 3'd1, 32'h0000_0000);
        check_read("rst_cmp_lo",   3'd2, 32'hFFFF_FFFF);
        check_read("rst_cmp_hi",   3'd3, 32'hFFFF_FFFF);
        check_read("rst_ctrl",     3'd4, 32'h0000_0000);
        check_read("rst_prescale", 3'd5, 32'h0000_0000);
        check_read("rst_off6",     3'd6, 32'h0000_0000);
        check_read("rst_off7",     3'd7, 32'h0000_0000);

        // PRESCALE is 16 bits with byte-lane writes
        write_reg(3'd5, 32'hDEAD_BEEF, 4'hF);
        check_read("prescale_16b", 3'd5, 32'h0000_BEEF);
        write_reg(3'd5, 32'h0000_0012, 4'h1);
        check_read("prescale_strb", 3'd5, 32'h0000_BE12);

        // PRESCALE = 3: one tick every 4 cycles
        write_reg(3'd5, 32'd3, 4'hF);
        write_reg(3'd4, 32'd1, 4'hF);
        idle(12);
        check_read("presc3_after12", 3'd0, 32'd3);
        idle(2);
        check_read("presc3_pre_tick", 3'd0, 32'd3);
        check_read("presc3_post_tick", 3'd0, 32'd4);
        check_read("ctrl_en", 3'd4, 32'd1);

        // EN = 0 freezes mtime
        write_reg(3'd4, 32'd0, 4'hF);
        idle(5);
        check_read("freeze_lo", 3'd0, 32'd4);
        check_read("ctrl_off", 3'd4, 32'd0);

        // Carry from LO into HI
        write_reg(3'd5, 32'd0, 4'hF);
        write_reg(3'd1, 32'd0, 4'hF);
        write_reg(3'd0, 32'hFFFF_FFFF, 4'hF);
        write_reg(3'd4, 32'd1, 4'hF);
        idle(1);
        check_read("carry_lo", 3'd0, 32'd0);
        check_read("carry_hi", 3'd1, 32'd1);

        // 64-bit wrap to zero
        write_reg(3'd4, 32'd0, 4'hF);
        write_reg(3'd1, 32'hFFFF_FFFF, 4'hF);
        write_reg(3'd0, 32'hFFFF_FFFF, 4'hF);
        write_reg(3'd4, 32'd1, 4'hF);
        idle(1);
        check_read("wrap_lo", 3'd0, 32'd0);
        check_read("wrap_hi", 3'd1, 32'd0);

        // Compare interrupt: mtimecmp = 10
        write_reg(3'd4, 32'd0, 4'hF);
        write_reg(3'd3, 32'd0, 4'hF);
        write_reg(3'd2, 32'd10, 4'hF);
        write_reg(3'd0, 32'd0, 4'hF);
        check_output("int_disabled", {31'd0, int_timer}, 32'd0);
        write_reg(3'd4, 32'd1, 4'hF);
        idle(10);
        check_output("int_at_reach", {31'd0, int_timer}, 32'd0);
        idle(1);
        check_output("int_rise", {31'd0, int_timer}, 32'd1);
        write_reg(3'd3, 32'd1, 4'hF);
        check_output("int_hold_on_write", {31'd0, int_timer}, 32'd1);
        idle(1);
        check_output("int_drop", {31'd0, int_timer}, 32'd0);
        check_read("cmp_hi", 3'd3, 32'd1);
        check_read("cmp_lo", 3'd2, 32'd10);

        // Partial write in a tick cycle drops the increment
        write_reg(3'd1, 32'd0, 4'hF);
        write_reg(3'd0, 32'hFFFF_FFFF, 4'hF);
        write_reg(3'd0, 32'hAABB_CCDD, 4'b0010);
        check_read("strb_lo", 3'd0, 32'hFFFF_CCFF);
        check_read("strb_hi", 3'd1, 32'd0);

        // Read data holds across idle cycles
        write_reg(3'd4, 32'd0, 4'hF);
        check_read("frozen_lo", 3'd0, 32'hFFFF_CD02);
        idle(3);
        check_output("rdata_hold", bus_if.rdata_o, 32'hFFFF_CD02);

        // Unselected and ignored accesses
        apply_stimulus(1'b1, BASE + 32'h40, 32'd0, 4'h0, 1'b0);
        check_output("unsel_read", bus_if.rdata_o, 32'd0);
        write_reg(3'd7, 32'hFFFF_FFFF, 4'hF);
        check_read("off7_read", 3'd7, 32'd0);
        apply_stimulus(1'b1, BASE + 32'h40, 32'h1234_5678, 4'hF, 1'b1);
        apply_stimulus(1'b0, BASE, 32'h1234_5678, 4'hF, 1'b1);
        check_read("unsel_lo", 3'd0, 32'hFFFF_CD02);
        check_read("unsel_hi", 3'd1, 32'd0);
        check_read("unsel_ctrl", 3'd4, 32'd0);
        check_read("unsel_cmp_lo", 3'd2, 32'd10);

        // Reset wins over a same-cycle write
        rst = 1'b1;
        apply_stimulus(1'b1, BASE, 32'd5, 4'hF, 1'b1);
        rst = 1'b0;
        check_output("rst_over_rdata", bus_if.rdata_o, 32'd0);
        check_output("rst_over_int", {31'd0, int_timer}, 32'd0);
        check_read("rst_over_lo", 3'd0, 32'd0);
        check_read("rst_over_cmp", 3'd2, 32'hFFFF_FFFF);
        check_read("rst_over_pres", 3'd5, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
